// File: rtl/matrix_coef_bus_bridge_if.sv
// System-bus side of the coefficient bridge: single-cycle read/write strobes
// with a registered one-cycle ack/err/rdata response.
interface matrix_coef_bus_bridge_if;
    logic [31:0] sys_addr;
    logic [31:0] sys_wdata;
    logic        sys_wen;
    logic        sys_ren;
    logic [31:0] sys_rdata;
    logic        sys_ack;
    logic        sys_err;

    modport master (
        output sys_addr, sys_wdata, sys_wen, sys_ren,
        input  sys_rdata, sys_ack, sys_err
    );

    modport slave (
        input  sys_addr, sys_wdata, sys_wen, sys_ren,
        output sys_rdata, sys_ack, sys_err
    );
endinterface

// File: rtl/matrix_coef_bus_bridge.sv
// Bus bridge feeding the 3x3 matrix coefficient bank.
// Writes become a one-cycle valid pulse on cfg_w, followed by a settle cycle so
// that any read issued afterwards samples the already-updated bank state.
// Strobes arriving while a write is in flight wait in a 1-deep pending slot.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// IDLE       | serve pending slot first, else a new strobe
// WR_POST    | cfg_w valid is high, bank captures it at the end of this cycle
// WR_SETTLE  | bank register now updated; strobes still go to the slot
module matrix_coef_bus_bridge #(
    parameter logic [19:0] ADDR_BASE = 20'h00040,
    parameter int unsigned NWORDS    = 8
) (
    input  logic                    system1000,
    input  logic                    system1000_rstn,
    matrix_coef_bus_bridge_if.slave sys,
    output logic [52:0]             cfg_w,
    input  logic [NWORDS*32-1:0]    cfg_regs,
    output logic                    ovf,
    input  logic                    ovf_clr
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WR_POST   = 2'd1,
        WR_SETTLE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [52:0] cfg_w_q, cfg_w_d;
    logic        ovf_q, ovf_d;

    logic        pend_vld_q, pend_vld_d;
    logic [19:0] pend_addr_q, pend_addr_d;
    logic [31:0] pend_wdata_q, pend_wdata_d;
    logic        pend_wen_q, pend_wen_d;
    logic        pend_ren_q, pend_ren_d;

    logic        new_strb;
    logic        req_vld;
    logic [19:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_wen;
    logic        req_ren;
    logic        overflow;
    logic        unused_addr_hi;

    // Upper bus address bits are outside the 20-bit bank address space.
    assign unused_addr_hi = ^sys.sys_addr[31:20];
    assign new_strb       = sys.sys_wen | sys.sys_ren;

    // Next-state, request selection, pending-slot management and response.
    always_comb begin
        state_d      = state_q;
        rdata_d      = '0;
        ack_d        = 1'b0;
        err_d        = 1'b0;
        cfg_w_d      = {1'b0, cfg_w_q[51:0]};
        ovf_d        = ovf_q;
        pend_vld_d   = pend_vld_q;
        pend_addr_d  = pend_addr_q;
        pend_wdata_d = pend_wdata_q;
        pend_wen_d   = pend_wen_q;
        pend_ren_d   = pend_ren_q;
        req_vld      = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        req_wen      = 1'b0;
        req_ren      = 1'b0;
        overflow     = 1'b0;

        case (state_q)
            IDLE: begin
                if (pend_vld_q) begin
                    // The slot goes first; a strobe in this same cycle refills it.
                    req_vld    = 1'b1;
                    req_addr   = pend_addr_q;
                    req_wdata  = pend_wdata_q;
                    req_wen    = pend_wen_q;
                    req_ren    = pend_ren_q;
                    pend_vld_d = new_strb;
                    if (new_strb) begin
                        pend_addr_d  = sys.sys_addr[19:0];
                        pend_wdata_d = sys.sys_wdata;
                        pend_wen_d   = sys.sys_wen;
                        pend_ren_d   = sys.sys_ren;
                    end
                end else if (new_strb) begin
                    req_vld   = 1'b1;
                    req_addr  = sys.sys_addr[19:0];
                    req_wdata = sys.sys_wdata;
                    req_wen   = sys.sys_wen;
                    req_ren   = sys.sys_ren;
                end
            end
            WR_POST, WR_SETTLE: begin
                state_d = (state_q == WR_POST) ? WR_SETTLE : IDLE;
                if (new_strb) begin
                    if (pend_vld_q) begin
                        overflow = 1'b1;
                    end else begin
                        pend_vld_d   = 1'b1;
                        pend_addr_d  = sys.sys_addr[19:0];
                        pend_wdata_d = sys.sys_wdata;
                        pend_wen_d   = sys.sys_wen;
                        pend_ren_d   = sys.sys_ren;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (req_vld) begin
            ack_d = 1'b1;
            if ((req_wen && req_ren) || (req_addr[1:0] != 2'b00)) begin
                err_d = 1'b1;
            end else if (req_wen) begin
                cfg_w_d = {1'b1, req_addr, req_wdata};
                state_d = WR_POST;
            end else if (req_addr[19:5] == ADDR_BASE[19:5]) begin
                rdata_d = cfg_regs[{req_addr[4:2], 5'b00000} +: 32];
            end else begin
                err_d = 1'b1;
            end
        end

        // A new overflow beats a simultaneous clear.
        if (overflow) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    // State and output registers; reset drops any in-flight write at once.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            state_q      <= IDLE;
            rdata_q      <= '0;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
            cfg_w_q      <= '0;
            ovf_q        <= 1'b0;
            pend_vld_q   <= 1'b0;
            pend_addr_q  <= '0;
            pend_wdata_q <= '0;
            pend_wen_q   <= 1'b0;
            pend_ren_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rdata_q      <= rdata_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            cfg_w_q      <= cfg_w_d;
            ovf_q        <= ovf_d;
            pend_vld_q   <= pend_vld_d;
            pend_addr_q  <= pend_addr_d;
            pend_wdata_q <= pend_wdata_d;
            pend_wen_q   <= pend_wen_d;
            pend_ren_q   <= pend_ren_d;
        end
    end

    assign sys.sys_rdata = rdata_q;
    assign sys.sys_ack   = ack_q;
    assign sys.sys_err   = err_q;
    assign cfg_w         = cfg_w_q;
    assign ovf           = ovf_q;

endmodule

// File: tb/tb_matrix_coef_bus_bridge.sv
// Directed bench for matrix_coef_bus_bridge with a small coefficient-bank model.
// Inputs change 1ns after a rising edge; outputs are checked at that point too.
module tb_matrix_coef_bus_bridge;

    logic         clk;
    logic         rstn;
    logic         ovf_clr;
    logic         bank_init;
    logic [255:0] cfg_regs;
    logic [52:0]  cfg_w;
    logic         ovf;
    logic [19:0]  bank_a;

    int n_chk;
    int n_bad;

    matrix_coef_bus_bridge_if bus ();

    matrix_coef_bus_bridge dut (
        .system1000      (clk),
        .system1000_rstn (rstn),
        .sys             (bus.slave),
        .cfg_w           (cfg_w),
        .cfg_regs        (cfg_regs),
        .ovf             (ovf),
        .ovf_clr         (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bank model: word i preset to 0x1000+i, updated by in-window aligned writes.
    assign bank_a = cfg_w[51:32];
    always @(posedge clk) begin
        if (bank_init) begin
            for (int i = 0; i < 8; i++) cfg_regs[i*32 +: 32] <= 32'h1000 + 32'(i);
        end else if (cfg_w[52] && bank_a[19:5] == 15'h0002 && bank_a[1:0] == 2'b00) begin
            cfg_regs[{bank_a[4:2], 5'b00000} +: 32] <= cfg_w[31:0];
        end
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
        bus.sys_wen   = w;
        bus.sys_ren   = r;
        bus.sys_addr  = a;
        bus.sys_wdata = d;
    endtask

    task automatic quiet();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic chk_resp(input string tag, input logic a, input logic e, input logic [31:0] d);
        chk({tag, "_ack"}, 64'(bus.sys_ack), 64'(a));
        chk({tag, "_err"}, 64'(bus.sys_err), 64'(e));
        chk({tag, "_rdata"}, 64'(bus.sys_rdata), 64'(d));
    endtask

    initial begin
        n_chk     = 0;
        n_bad     = 0;
        rstn      = 1'b0;
        ovf_clr   = 1'b0;
        bank_init = 1'b1;
        quiet();
        repeat (3) @(posedge clk);
        #1;
        chk_resp("rst", 1'b0, 1'b0, 32'h0);
        chk("rst_cfg_w", 64'(cfg_w), 64'h0);
        chk("rst_ovf", 64'(ovf), 64'h0);
        rstn      = 1'b1;
        bank_init = 1'b0;
        step();

        // Back-to-back in-window reads, then an out-of-window read.
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 32'h40 + 32'(4 * i), 32'h0);
            step();
            chk_resp($sformatf("rd%0d", i), 1'b1, 1'b0, 32'h1000 + 32'(i));
        end
        drive(1'b0, 1'b1, 32'h60, 32'h0);
        step();
        chk_resp("rd_oow", 1'b1, 1'b1, 32'h0);
        quiet();
        step();
        chk("rd_oow_single_ack", 64'(bus.sys_ack), 64'h0);

        // Basic write timing; IDLE at cycle 3 shown by an immediate read ack.
        drive(1'b1, 1'b0, 32'h44, 32'h3F800000);
        step();
        quiet();
        chk("wr_c1_cfg_w", 64'(cfg_w), {11'h0, 1'b1, 20'h00044, 32'h3F800000});
        chk_resp("wr_c1", 1'b1, 1'b0, 32'h0);
        step();
        chk("wr_c2_cfg_w", 64'(cfg_w), {11'h0, 1'b0, 20'h00044, 32'h3F800000});
        chk("wr_c2_ack", 64'(bus.sys_ack), 64'h0);
        step();
        drive(1'b0, 1'b1, 32'h44, 32'h0);
        step();
        quiet();
        chk_resp("wr_c3_rd", 1'b1, 1'b0, 32'h3F800000);

        // Read-after-write through the pending slot returns the new value.
        step();
        drive(1'b1, 1'b0, 32'h48, 32'hCAFE0001);
        step();
        chk("raw_wr_ack", 64'(bus.sys_ack), 64'h1);
        drive(1'b0, 1'b1, 32'h48, 32'h0);
        step();
        quiet();
        chk("raw_c2_ack", 64'(bus.sys_ack), 64'h0);
        step();
        chk("raw_c3_ack", 64'(bus.sys_ack), 64'h0);
        step();
        chk_resp("raw_c4", 1'b1, 1'b0, 32'hCAFE0001);

        // Misaligned write and wen+ren: error ack, no cfg_w pulse, no busy time.
        step();
        drive(1'b1, 1'b0, 32'h42, 32'hDEAD0000);
        step();
        quiet();
        chk_resp("mis", 1'b1, 1'b1, 32'h0);
        chk("mis_valid", 64'(cfg_w[52]), 64'h0);
        step();
        chk("mis_valid_c2", 64'(cfg_w[52]), 64'h0);
        drive(1'b1, 1'b1, 32'h44, 32'h12345678);
        step();
        chk_resp("both", 1'b1, 1'b1, 32'h0);
        chk("both_valid", 64'(cfg_w[52]), 64'h0);
        drive(1'b0, 1'b1, 32'h40, 32'h0);
        step();
        quiet();
        chk_resp("both_nobusy_rd", 1'b1, 1'b0, 32'h1000);
        chk("both_valid_c2", 64'(cfg_w[52]), 64'h0);

        // Overflow: second strobe while busy is dropped and sets ovf.
        step();
        drive(1'b1, 1'b0, 32'h4C, 32'h00000055);
        step();
        chk("ovf_wr_ack", 64'(bus.sys_ack), 64'h1);
        drive(1'b0, 1'b1, 32'h40, 32'h0);
        step();
        chk("ovf_c2_ack", 64'(bus.sys_ack), 64'h0);
        drive(1'b0, 1'b1, 32'h44, 32'h0);
        step();
        quiet();
        chk("ovf_c3_ack", 64'(bus.sys_ack), 64'h0);
        chk("ovf_set", 64'(ovf), 64'h1);
        step();
        chk_resp("ovf_slot", 1'b1, 1'b0, 32'h1000);
        step();
        chk("ovf_drop_noack", 64'(bus.sys_ack), 64'h0);
        chk("ovf_sticky", 64'(ovf), 64'h1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf_clr", 64'(ovf), 64'h0);

        // Overflow and clear in the same cycle: set wins.
        drive(1'b1, 1'b0, 32'h50, 32'h00000066);
        step();
        drive(1'b0, 1'b1, 32'h40, 32'h0);
        step();
        drive(1'b0, 1'b1, 32'h44, 32'h0);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        quiet();
        chk("ovf_set_wins", 64'(ovf), 64'h1);
        step();
        chk_resp("ovf2_slot", 1'b1, 1'b0, 32'h1000);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf_clr2", 64'(ovf), 64'h0);

        // Reset during WR_POST drops the write immediately.
        drive(1'b1, 1'b0, 32'h54, 32'h00000077);
        step();
        quiet();
        chk("rpost_valid", 64'(cfg_w[52]), 64'h1);
        #2;
        rstn = 1'b0;
        #1;
        chk("rpost_cfg_w", 64'(cfg_w), 64'h0);
        chk("rpost_ack", 64'(bus.sys_ack), 64'h0);
        step();
        rstn = 1'b1;
        step();
        drive(1'b0, 1'b1, 32'h40, 32'h0);
        step();
        quiet();
        chk_resp("rpost_rd", 1'b1, 1'b0, 32'h1000);

        // Reset with a captured strobe in the slot: the slot must not survive.
        step();
        drive(1'b1, 1'b0, 32'h58, 32'h00000088);
        step();
        drive(1'b0, 1'b1, 32'h40, 32'h0);
        step();
        quiet();
        #2;
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("rslot_noack%0d", i), 64'(bus.sys_ack), 64'h0);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/matrix_coef_bus_bridge.md
Name: matrix_coef_bus_bridge

Overview:
- Upstream feeder for the 3x3 matrix-multiply coefficient register bank.
- Converts single-cycle system-bus read/write strobes into the bank's 53-bit write word {valid, addr[19:0], data[31:0]}.
- Serves readback of the bank's 8x32-bit state vector.
- Sequences writes so that a read issued after a write always returns the updated coefficient.

Parameters:
- ADDR_BASE, 20'h00040: base of the 8-word readback window (32-byte aligned); word i sits at ADDR_BASE + 4*i.
- NWORDS, 8: number of 32-bit words in cfg_regs; fixed at 8.

Ports:
- system1000  in  1  clock.
- system1000_rstn  in  1  asynchronous reset, active low.
- sys_addr  in  32  bus address; only [19:0] is used.
- sys_wdata  in  32  write data.
- sys_wen  in  1  write strobe, one cycle.
- sys_ren  in  1  read strobe, one cycle.
- sys_rdata  out  32  read data.
- sys_ack  out  1  response strobe, one cycle.
- sys_err  out  1  error qualifier, valid with sys_ack.
- cfg_w  out  53  to the bank: [52] valid, [51:32] addr, [31:0] data.
- cfg_regs  in  256  bank state; word i = cfg_regs[i*32+:32].
- ovf  out  1  sticky request-overflow flag.
- ovf_clr  in  1  synchronous clear of ovf.

Behaviour:
- Reset: all outputs 0 (sys_rdata, sys_ack, sys_err, cfg_w, ovf); FSM = IDLE; pending slot empty. Reset mid-write drops the write; cfg_w[52] falls immediately.
- FSM states: IDLE, WR_POST, WR_SETTLE.
- IDLE, write accepted at cycle N, then:
  - N+1: state WR_POST; cfg_w = {1, sys_addr[19:0], sys_wdata} (registered); sys_ack=1; sys_err=0.
  - N+2: state WR_SETTLE; cfg_w[52]=0 (addr/data fields hold their values); the bank updates its register this edge.
  - N+3: state IDLE.
  - cfg_w[52] is high for exactly one cycle per write.
- IDLE, read accepted at cycle N, then:
  - N+1: sys_ack=1; sys_rdata = cfg_regs word sys_addr[4:2], sampled at N.
  - Reads do not leave IDLE; back-to-back reads give one ack per cycle.
- Decode:
  - Window hit when sys_addr[19:5] == ADDR_BASE[19:5].
  - Writes are forwarded regardless of window; address matching is the bank's job.
  - Out-of-window read: ack, err=1, rdata=0.
- Errors:
  - Misaligned access (sys_addr[1:0] != 0): ack with err=1 and rdata=0. No cfg_w pulse. No busy time.
  - sys_wen and sys_ren both high: ack with err=1. Nothing forwarded.
- Busy capture:
  - A strobe arriving in WR_POST or WR_SETTLE is latched into a 1-deep pending slot (addr, wdata, wen, ren).
  - The slot is served on the first IDLE cycle as if strobed that cycle, so its response comes one cycle later.
  - The slot is served before any new strobe arriving in that same cycle; that new strobe is then captured into the slot again.
- Overflow:
  - A strobe arriving while the slot is full is dropped: no ack, ovf set to 1.
  - ovf_clr clears ovf. If ovf_clr and a new overflow occur in the same cycle, set wins.
- sys_ack is never high on two consecutive cycles for the same request. sys_err=0 whenever sys_ack=0.
- No combinational path from sys_* inputs to any output; all outputs are registered.

Test Plan:
- Reset, then write 0x3F800000 to addr 0x00044 at cycle 0 -> cycle 1: cfg_w = {1, 20'h00044, 32'h3F800000}, ack=1, err=0. Cycle 2: cfg_w[52]=0. Cycle 3: IDLE.
- Write to 0x00048, then read 0x00048 one cycle later (captured while busy), with a bank model connected -> read served at cycle 3; ack at cycle 4 with rdata equal to the written data, not the stale value.
- Reads of 0x00040..0x0005C on 8 consecutive cycles with cfg_regs word i = 0x1000+i -> 8 consecutive acks, rdata 0x1000..0x1007. Read 0x00060 -> ack, err=1, rdata=0.
- Misaligned write to 0x00042, and simultaneous wen+ren -> each gives ack, err=1, and no cfg_w[52] pulse.
- Write, then two further strobes during WR_POST and WR_SETTLE -> first is served at IDLE, second is dropped with no ack, ovf=1. ovf_clr=1 -> ovf=0 next cycle. Overflow together with clr in the same cycle -> ovf=1.
- Assert system1000_rstn=0 during WR_POST -> cfg_w, ack, and pending slot are 0/empty immediately. After release, a fresh read completes normally.
